register_file_mp: RTL and testbench
===================================

# register_file_mp

Parametrised multi-port register file with an integrated busy scoreboard, for wider-issue datapath generations. Supports configurable data width, register count, read-port and write-port count, optional same-cycle write-to-read bypass and an optional hardwired zero register. Per-register busy bits are set by a reservation port and cleared by writeback, so decode logic can detect RAW hazards without an external scoreboard. Sits between decode (read, reserve) and writeback (write).

## Interface

- DW, 32, data width in bits
- NREGS, 32, number of registers (power of two, ≥2)
- AW, $clog2(NREGS), select width (derived; do not override)
- NRD, 2, number of read ports (≥1)
- NWR, 1, number of write ports (≥1)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and never goes busy

- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  asynchronous reset, active low
- wen  in  NWR  write enable per write port
- wsel  in  NWR*AW  write select; port i at bits [i*AW +: AW]
- wdat  in  NWR*DW  write data; port i at bits [i*DW +: DW]
- rsel  in  NRD*AW  read select; port j at bits [j*AW +: AW]
- rdat  out  NRD*DW  read data; port j at bits [j*DW +: DW]; combinational
- rbusy  out  NRD  busy flag of register selected by port j; combinational
- rsv_en  in  1  reserve: mark register rsv_sel busy
- rsv_sel  in  AW  register to reserve
- flush  in  1  clear every busy bit
- busy  out  NREGS  registered busy vector
- wconflict  out  1  registered: ≥2 enabled write ports hit the same register in the previous cycle

## Operation

- Storage: NREGS × DW registers. Write on rising CLK for each port i with wen[i]=1.
- Same-register multi-write: highest-indexed enabled port wins; wconflict=1 for exactly the following cycle. A select of 0 counts toward the conflict check even when ZERO_REG=1.
- ZERO_REG=1: writes to reg 0 dropped; rdat for rsel=0 is 0; reserve of reg 0 ignored; busy[0] is always 0.
- Read: rdat[j] = stored value of rsel[j].
- Bypass (BYPASS=1): if any enabled write port targets rsel[j] (non-zero when ZERO_REG=1), rdat[j] = wdat of the highest-indexed such port, and rbusy[j]=0.
- Otherwise rbusy[j] = busy[rsel[j]].
- Busy bit update per register r, in priority order:
  - flush → 0
  - rsv_en && rsv_sel==r → 1 (a new producer wins over a same-cycle writeback)
  - any wen[i] with wsel[i]==r → 0
  - else hold.
- Writes are never blocked by busy state. Busy is advisory only.

## Timing

- Reset (nRST=0, asynchronous): all registers 0, busy all 0, wconflict 0. During reset rdat is all 0 and rbusy is all 0.
- Deassertion is assumed synchronous to CLK upstream.
- Reset mid-operation: immediate clear; pending same-cycle writes and reserves are lost.
- Write-to-read latency:
  - BYPASS=1: 0 cycles (same cycle).
  - BYPASS=0: visible the cycle after the write edge.
- Reserve-to-busy latency: 1 cycle (busy and rbusy reflect it after the edge).
- wconflict: 1-cycle pulse per conflicting cycle; high continuously if conflicts persist.
- No handshakes. Every request is accepted every cycle.

## Test plan

- Reset with prior nonzero state: assert nRST=0 mid-cycle → rdat=0, busy=0, wconflict=0 immediately, without waiting for a CLK edge.
- Basic write and read, BYPASS=0: write 0xDEADBEEF to r5 → same cycle rdat(rsel=5)=old value; next cycle rdat=0xDEADBEEF on every read port.
- Bypass, BYPASS=1, NWR=2:
  - Port0 writes 0x11 and port1 writes 0x22 to r7, with rsel0=7 → rdat0=0x22 in the same cycle.
  - r7 holds 0x22 afterwards; wconflict=1 for the next cycle only.
- Zero register: write 0xFFFF_FFFF to r0 and reserve r0 → rdat(r0)=0, busy[0]=0, even with BYPASS=1.
- Scoreboard sequence:
  - Reserve r3 → busy[3]=1 next cycle; rbusy=1 when reading r3.
  - Write r3 with reserve r3 in the same cycle → busy[3] stays 1.
  - Write r3 alone → busy[3]=0.
  - Reserve r9 with flush → busy=0.
- Parameter sweep: DW=64, NREGS=16, NRD=4, NWR=2 → random writes and reads checked against a reference model for 10k cycles, with no mismatches.

Source files
------------

// File: rtl/register_file_mp_if.sv
// register_file_mp_if: bus bundle for the multi-port register file.
// Groups the write ports, read ports, reservation/flush controls and the
// scoreboard outputs. The register file connects through the slave modport;
// the decode/writeback side (or a testbench) drives it through the master modport.
//   wen/wsel/wdat      : NWR write ports, port i at [i*AW +: AW] / [i*DW +: DW]
//   rsel/rdat/rbusy    : NRD read ports, port j at [j*AW +: AW] / [j*DW +: DW]
//   rsv_en/rsv_sel     : mark one register busy
//   flush              : clear every busy bit
//   busy/wconflict     : registered scoreboard vector and write-collision flag
interface register_file_mp_if #(
    parameter int DW    = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    logic [NWR-1:0]    wen;
    logic [NWR*AW-1:0] wsel;
    logic [NWR*DW-1:0] wdat;
    logic [NRD*AW-1:0] rsel;
    logic [NRD*DW-1:0] rdat;
    logic [NRD-1:0]    rbusy;
    logic              rsv_en;
    logic [AW-1:0]     rsv_sel;
    logic              flush;
    logic [NREGS-1:0]  busy;
    logic              wconflict;

    modport master (
        output wen, wsel, wdat, rsel, rsv_en, rsv_sel, flush,
        input  rdat, rbusy, busy, wconflict
    );

    modport slave (
        input  wen, wsel, wdat, rsel, rsv_en, rsv_sel, flush,
        output rdat, rbusy, busy, wconflict
    );
endinterface

// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-port register file with busy scoreboard.
// Ports:
//   CLK  - clock, all state updates on the rising edge
//   nRST - asynchronous active-low reset (clears storage, busy and wconflict)
//   bus  - register_file_mp_if slave modport (write/read ports, reserve,
//          flush, busy vector, wconflict)
// Reads are combinational. With BYPASS=1 a same-cycle write to the selected
// register is forwarded (highest-indexed write port wins). With ZERO_REG=1
// register 0 reads as zero, drops writes and never goes busy.
module register_file_mp #(
    parameter int DW       = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input logic                CLK,
    input logic                nRST,
    register_file_mp_if.slave  bus
);

    localparam bit BYPASS_ON = (BYPASS != 32'sd0);
    localparam bit ZERO_ON   = (ZERO_REG != 32'sd0);

    logic [DW-1:0]     regs_r [NREGS];
    logic [NREGS-1:0]  busy_r;
    logic [NREGS-1:0]  busy_nxt_s;
    logic              wconflict_r;
    logic              wconflict_s;
    logic [NRD*DW-1:0] rdat_s;
    logic [NRD-1:0]    rbusy_s;
    logic [AW-1:0]     rd_sel_s;
    logic              rd_hit_s;
    logic              hit_now_s;
    logic [DW-1:0]     rd_fwd_s;

    // True when the select addresses the hardwired zero register.
    function automatic logic is_zero_sel(input logic [AW-1:0] sel);
        return ZERO_ON && (sel == {AW{1'b0}});
    endfunction

    // Storage update: ports are applied in ascending order so the
    // highest-indexed enabled port's assignment is the one that lands.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_r[r] <= {DW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (bus.wen[i] && !is_zero_sel(bus.wsel[i*AW +: AW])) begin
                    regs_r[bus.wsel[i*AW +: AW]] <= bus.wdat[i*DW +: DW];
                end
            end
        end
    end

    // Next busy vector: writeback clears, then reserve sets (new producer
    // beats a same-cycle writeback), then flush overrides everything.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < NWR; i++) begin
            busy_nxt_s[bus.wsel[i*AW +: AW]] =
                bus.wen[i] ? 1'b0 : busy_nxt_s[bus.wsel[i*AW +: AW]];
        end
        busy_nxt_s[bus.rsv_sel] = bus.rsv_en ? 1'b1 : busy_nxt_s[bus.rsv_sel];
        if (bus.flush) begin
            busy_nxt_s = {NREGS{1'b0}};
        end else begin
            busy_nxt_s[0] = ZERO_ON ? 1'b0 : busy_nxt_s[0];
        end
    end

    // Collision detect: any pair of enabled write ports with equal selects,
    // register 0 included regardless of ZERO_REG.
    always_comb begin
        wconflict_s = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            for (int k = i + 1; k < NWR; k++) begin
                wconflict_s = wconflict_s |
                    (bus.wen[i] & bus.wen[k] &
                     (bus.wsel[i*AW +: AW] == bus.wsel[k*AW +: AW]));
            end
        end
    end

    // Scoreboard and collision flag registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_r      <= {NREGS{1'b0}};
            wconflict_r <= 1'b0;
        end else begin
            busy_r      <= busy_nxt_s;
            wconflict_r <= wconflict_s;
        end
    end

    // Read ports: zero register / reset force 0, else bypass, else storage.
    always_comb begin
        rdat_s    = {(NRD*DW){1'b0}};
        rbusy_s   = {NRD{1'b0}};
        rd_sel_s  = {AW{1'b0}};
        rd_hit_s  = 1'b0;
        hit_now_s = 1'b0;
        rd_fwd_s  = {DW{1'b0}};
        for (int j = 0; j < NRD; j++) begin
            rd_sel_s = bus.rsel[j*AW +: AW];
            rd_hit_s = 1'b0;
            rd_fwd_s = {DW{1'b0}};
            for (int i = 0; i < NWR; i++) begin
                hit_now_s = bus.wen[i] && (bus.wsel[i*AW +: AW] == rd_sel_s);
                rd_fwd_s  = hit_now_s ? bus.wdat[i*DW +: DW] : rd_fwd_s;
                rd_hit_s  = rd_hit_s | hit_now_s;
            end
            if (!nRST || is_zero_sel(rd_sel_s)) begin
                rdat_s[j*DW +: DW] = {DW{1'b0}};
                rbusy_s[j]         = 1'b0;
            end else if (BYPASS_ON && rd_hit_s) begin
                rdat_s[j*DW +: DW] = rd_fwd_s;
                rbusy_s[j]         = 1'b0;
            end else begin
                rdat_s[j*DW +: DW] = regs_r[rd_sel_s];
                rbusy_s[j]         = busy_r[rd_sel_s];
            end
        end
    end

    assign bus.rdat      = rdat_s;
    assign bus.rbusy     = rbusy_s;
    assign bus.busy      = busy_r;
    assign bus.wconflict = wconflict_r;

endmodule

// File: tb/tb_register_file_mp.sv
// Testbench for register_file_mp. Two instances share identical stimulus:
//   inst 0 (dut_a): BYPASS=1, ZERO_REG=1
//   inst 1 (dut_b): BYPASS=0, ZERO_REG=0
// both with DW=64, NREGS=16, NRD=4, NWR=2. A behavioural model (arrays of
// register values and busy bits) predicts every output each cycle.
module tb_register_file_mp;
    localparam int DW  = 64;
    localparam int NR  = 16;
    localparam int AW  = 4;
    localparam int NRD = 4;
    localparam int NWR = 2;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic [NWR-1:0]    wen_t;
    logic [NWR*AW-1:0] wsel_t;
    logic [NWR*DW-1:0] wdat_t;
    logic [NRD*AW-1:0] rsel_t;
    logic              rsv_en_t;
    logic [AW-1:0]     rsv_sel_t;
    logic              flush_t;

    register_file_mp_if #(.DW(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR)) bus_a ();
    register_file_mp_if #(.DW(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR)) bus_b ();

    assign bus_a.wen = wen_t;   assign bus_b.wen = wen_t;
    assign bus_a.wsel = wsel_t; assign bus_b.wsel = wsel_t;
    assign bus_a.wdat = wdat_t; assign bus_b.wdat = wdat_t;
    assign bus_a.rsel = rsel_t; assign bus_b.rsel = rsel_t;
    assign bus_a.rsv_en = rsv_en_t;   assign bus_b.rsv_en = rsv_en_t;
    assign bus_a.rsv_sel = rsv_sel_t; assign bus_b.rsv_sel = rsv_sel_t;
    assign bus_a.flush = flush_t;     assign bus_b.flush = flush_t;

    register_file_mp #(.DW(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR),
                       .BYPASS(1), .ZERO_REG(1))
        dut_a (.CLK(CLK), .nRST(nRST), .bus(bus_a));
    register_file_mp #(.DW(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR),
                       .BYPASS(0), .ZERO_REG(0))
        dut_b (.CLK(CLK), .nRST(nRST), .bus(bus_b));

    // Reference model state, index 0 = dut_a, 1 = dut_b
    logic [DW-1:0] mem_m [2][NR];
    logic [NR-1:0] busy_m [2];
    logic          wc_m [2];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [AW-1:0] ws(input int i);
        return wsel_t[i*AW +: AW];
    endfunction
    function automatic logic [DW-1:0] wd(input int i);
        return wdat_t[i*DW +: DW];
    endfunction
    function automatic logic [DW-1:0] rd_a(input int j);
        return bus_a.rdat[j*DW +: DW];
    endfunction
    function automatic logic [DW-1:0] rd_b(input int j);
        return bus_b.rdat[j*DW +: DW];
    endfunction

    task automatic idle();
        wen_t = '0; wsel_t = '0; wdat_t = '0; rsel_t = '0;
        rsv_en_t = 1'b0; rsv_sel_t = '0; flush_t = 1'b0;
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < NR; r++) mem_m[m][r] = '0;
            busy_m[m] = '0;
            wc_m[m] = 1'b0;
        end
    endtask

    // Apply one clock edge's worth of the rules to the model.
    task automatic model_edge();
        logic c;
        logic wr;
        bit   zr;
        c = 1'b0;
        for (int i = 0; i < NWR; i++)
            for (int k = i + 1; k < NWR; k++)
                if (wen_t[i] && wen_t[k] && ws(i) == ws(k)) c = 1'b1;
        for (int m = 0; m < 2; m++) begin
            zr = (m == 0);
            wc_m[m] = c;
            for (int r = 0; r < NR; r++) begin
                wr = 1'b0;
                for (int i = 0; i < NWR; i++) if (wen_t[i] && ws(i) == r) wr = 1'b1;
                if (flush_t) busy_m[m][r] = 1'b0;
                else if (rsv_en_t && rsv_sel_t == r && !(zr && r == 0)) busy_m[m][r] = 1'b1;
                else if (wr) busy_m[m][r] = 1'b0;
            end
            for (int i = 0; i < NWR; i++)
                if (wen_t[i] && !(zr && ws(i) == 0)) mem_m[m][ws(i)] = wd(i);
        end
    endtask

    task automatic exp_read(input int m, input int j, output logic [DW-1:0] d, output logic b);
        logic [AW-1:0] sel;
        logic hit;
        logic [DW-1:0] fwd;
        sel = rsel_t[j*AW +: AW];
        hit = 1'b0;
        fwd = '0;
        for (int i = 0; i < NWR; i++)
            if (wen_t[i] && ws(i) == sel) begin hit = 1'b1; fwd = wd(i); end
        if (m == 0 && sel == 0) begin d = '0; b = 1'b0; end
        else if (m == 0 && hit) begin d = fwd; b = 1'b0; end
        else begin d = mem_m[m][sel]; b = busy_m[m][sel]; end
    endtask

    task automatic check_all();
        logic [DW-1:0] d;
        logic b;
        for (int j = 0; j < NRD; j++) begin
            exp_read(0, j, d, b);
            chk($sformatf("a rdat[%0d]", j), rd_a(j), d);
            chk($sformatf("a rbusy[%0d]", j), bus_a.rbusy[j], b);
            exp_read(1, j, d, b);
            chk($sformatf("b rdat[%0d]", j), rd_b(j), d);
            chk($sformatf("b rbusy[%0d]", j), bus_b.rbusy[j], b);
        end
        chk("a busy", bus_a.busy, busy_m[0]);
        chk("b busy", bus_b.busy, busy_m[1]);
        chk("a wconflict", bus_a.wconflict, wc_m[0]);
        chk("b wconflict", bus_b.wconflict, wc_m[1]);
    endtask

    // Compare mid-cycle, then advance the model on the edge.
    task automatic cycle();
        @(negedge CLK);
        check_all();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic rand_stim();
        wen_t = 2'($urandom_range(0, 3));
        for (int i = 0; i < NWR; i++) begin
            wsel_t[i*AW +: AW] = 4'($urandom_range(0, NR - 1));
            wdat_t[i*DW +: DW] = {$urandom, $urandom};
        end
        for (int j = 0; j < NRD; j++)
            rsel_t[j*AW +: AW] = ($urandom_range(0, 1) == 1)
                ? ws(int'($urandom_range(0, NWR - 1)))
                : 4'($urandom_range(0, NR - 1));
        rsv_en_t = 1'($urandom_range(0, 1));
        rsv_sel_t = 4'($urandom_range(0, NR - 1));
        flush_t = ($urandom_range(0, 31) == 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int j = 0; j < NRD; j++) begin
            chk({tag, " a rdat"}, rd_a(j), 64'h0);
            chk({tag, " b rdat"}, rd_b(j), 64'h0);
            chk({tag, " a rbusy"}, bus_a.rbusy[j], 64'h0);
            chk({tag, " b rbusy"}, bus_b.rbusy[j], 64'h0);
        end
        chk({tag, " a busy"}, bus_a.busy, 64'h0);
        chk({tag, " b busy"}, bus_b.busy, 64'h0);
        chk({tag, " a wconflict"}, bus_a.wconflict, 64'h0);
        chk({tag, " b wconflict"}, bus_b.wconflict, 64'h0);
    endtask

    initial begin
        idle();
        model_reset();
        #1;
        check_reset_outputs("por");
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Write r5 (BYPASS=0 sees old value, BYPASS=1 sees new value)
        idle();
        wen_t = 2'b01; wsel_t[3:0] = 4'd5; wdat_t[63:0] = 64'hDEADBEEF;
        for (int j = 0; j < NRD; j++) rsel_t[j*AW +: AW] = 4'd5;
        #1;
        chk("b same-cycle old", rd_b(0), 64'h0);
        chk("a same-cycle bypass", rd_a(0), 64'hDEADBEEF);
        cycle();
        wen_t = 2'b00;
        #1;
        for (int j = 0; j < NRD; j++) chk("b next-cycle", rd_b(j), 64'hDEADBEEF);

        // Two ports hit r7: port1 wins, conflict pulse one cycle
        idle();
        wen_t = 2'b11; wsel_t = {4'd7, 4'd7};
        wdat_t = {64'h22, 64'h11}; rsel_t[3:0] = 4'd7;
        #1;
        chk("a bypass port1 wins", rd_a(0), 64'h22);
        chk("b no bypass", rd_b(0), 64'h0);
        cycle();
        idle(); rsel_t[3:0] = 4'd7;
        #1;
        chk("a r7 stored", rd_a(0), 64'h22);
        chk("b r7 stored", rd_b(0), 64'h22);
        chk("a wconflict pulse", bus_a.wconflict, 64'h1);
        chk("b wconflict pulse", bus_b.wconflict, 64'h1);
        cycle();
        #1;
        chk("a wconflict drops", bus_a.wconflict, 64'h0);

        // Zero register: write + reserve r0
        idle();
        wen_t = 2'b01; wdat_t[63:0] = 64'hFFFF_FFFF; rsv_en_t = 1'b1;
        #1;
        chk("a r0 no bypass", rd_a(0), 64'h0);
        cycle();
        idle();
        #1;
        chk("a r0 reads 0", rd_a(0), 64'h0);
        chk("a busy0 low", bus_a.busy[0], 64'h0);
        chk("b r0 written", rd_b(0), 64'hFFFF_FFFF);
        chk("b busy0 set", bus_b.busy[0], 64'h1);

        // Scoreboard sequence on r3
        idle(); rsv_en_t = 1'b1; rsv_sel_t = 4'd3;
        cycle();
        idle(); rsel_t[3:0] = 4'd3;
        #1;
        chk("a busy3 reserved", bus_a.busy[3], 64'h1);
        chk("a rbusy r3", bus_a.rbusy[0], 64'h1);
        wen_t = 2'b01; wsel_t[3:0] = 4'd3; wdat_t[63:0] = 64'h33;
        rsv_en_t = 1'b1; rsv_sel_t = 4'd3;
        #1;
        chk("a rbusy bypassed", bus_a.rbusy[0], 64'h0);
        chk("b rbusy no bypass", bus_b.rbusy[0], 64'h1);
        cycle();
        idle();
        #1;
        chk("a busy3 rsv beats wb", bus_a.busy[3], 64'h1);
        wen_t = 2'b01; wsel_t[3:0] = 4'd3;
        cycle();
        idle();
        #1;
        chk("a busy3 cleared", bus_a.busy[3], 64'h0);
        rsv_en_t = 1'b1; rsv_sel_t = 4'd9; flush_t = 1'b1;
        cycle();
        idle();
        #1;
        chk("a flush", bus_a.busy, 64'h0);
        chk("b flush", bus_b.busy, 64'h0);

        // Randomised run against the model
        for (int c = 0; c < 10000; c++) begin
            rand_stim();
            cycle();
        end

        // Asynchronous reset mid-cycle with traffic on the inputs
        rand_stim();
        wen_t = 2'b11;
        #2;
        nRST = 1'b0;
        #1;
        check_reset_outputs("mid");
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int c = 0; c < 200; c++) begin
            rand_stim();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
